// File: rtl/fft_pkg.sv
// Constants and FSM encoding shared by the FFT, modulus and peak-search stages.
// Compile-time only; no timing or backpressure of its own.
package fft_pkg;

    localparam int FFT_LEN_DEF = 128;
    localparam int DATA_W_DEF  = 12;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/spectrum_peak_detect_if.sv
// Magnitude stream in (no backpressure) and peak result out (valid/ready).
// Master is the upstream/consumer side; slave is the peak detector.
interface spectrum_peak_detect_if
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BIN_W  = $clog2(FFT_LEN_DEF)
);

    logic [DATA_W-1:0] data_modulus;
    logic              data_sop;
    logic              data_eop;
    logic              data_valid;
    logic [DATA_W-1:0] peak_mag;
    logic [BIN_W-1:0]  peak_bin;
    logic [DATA_W-1:0] dc_mag;
    logic              result_valid;
    logic              result_ready;
    logic              frame_err;
    logic              result_ovf;

    modport master (
        output data_modulus, data_sop, data_eop, data_valid, result_ready,
        input  peak_mag, peak_bin, dc_mag, result_valid, frame_err, result_ovf
    );

    modport slave (
        input  data_modulus, data_sop, data_eop, data_valid, result_ready,
        output peak_mag, peak_bin, dc_mag, result_valid, frame_err, result_ovf
    );

endinterface

// File: rtl/spectrum_peak_detect.sv
// Per-frame peak search over bins 1..FFT_LEN/2 plus DC capture; result 1 cycle after eop.
// Input never stalls; an unconsumed result is overwritten by the next frame (result_ovf pulse).
module spectrum_peak_detect
    import fft_pkg::*;
#(
    parameter int  FFT_LEN = FFT_LEN_DEF,
    parameter int  DATA_W  = DATA_W_DEF,
    localparam int BIN_W   = $clog2(FFT_LEN)
) (
    input  logic                  clk_50m,
    input  logic                  rst_n,
    spectrum_peak_detect_if.slave bus
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);
    localparam logic [BIN_W-1:0] HALF_BIN = BIN_W'(FFT_LEN / 2);

    state_t            r_state;
    logic [BIN_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_dc_work;
    logic [DATA_W-1:0] r_pk_mag_work;
    logic [BIN_W-1:0]  r_pk_bin_work;

    logic [DATA_W-1:0] r_peak_mag;
    logic [BIN_W-1:0]  r_peak_bin;
    logic [DATA_W-1:0] r_dc_mag;
    logic              r_result_valid;
    logic              r_frame_err;
    logic              r_result_ovf;

    logic w_handshake;
    logic w_last;
    logic w_in_range;
    logic w_greater;

    assign w_handshake = r_result_valid && bus.result_ready;
    assign w_last      = (r_cnt == LAST_BIN);
    assign w_in_range  = (r_cnt <= HALF_BIN);
    assign w_greater   = (bus.data_modulus > r_pk_mag_work);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_dc_work      <= '0;
            r_pk_mag_work  <= '0;
            r_pk_bin_work  <= '0;
            r_peak_mag     <= '0;
            r_peak_bin     <= '0;
            r_dc_mag       <= '0;
            r_result_valid <= 1'b0;
            r_frame_err    <= 1'b0;
            r_result_ovf   <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_result_ovf <= 1'b0;
            if (w_handshake) begin
                r_result_valid <= 1'b0;
            end

            if (bus.data_valid) begin
                case (r_state)
                    IDLE: begin
                        if (bus.data_sop) begin
                            r_cnt         <= BIN_W'(1);
                            r_dc_work     <= bus.data_modulus;
                            r_pk_mag_work <= '0;
                            r_pk_bin_work <= '0;
                            // sop+eop on one beat is a one-bin frame: start, then abort
                            if (bus.data_eop) begin
                                r_frame_err <= 1'b1;
                                r_state     <= IDLE;
                            end else begin
                                r_state     <= ACC;
                            end
                        end
                    end

                    ACC: begin
                        if (bus.data_sop) begin
                            r_frame_err   <= 1'b1;
                            r_cnt         <= BIN_W'(1);
                            r_dc_work     <= bus.data_modulus;
                            r_pk_mag_work <= '0;
                            r_pk_bin_work <= '0;
                            r_state       <= ACC;
                        end else if (w_last) begin
                            if (bus.data_eop) begin
                                r_peak_mag     <= r_pk_mag_work;
                                r_peak_bin     <= r_pk_bin_work;
                                r_dc_mag       <= r_dc_work;
                                r_result_valid <= 1'b1;
                                if (r_result_valid && !bus.result_ready) begin
                                    r_result_ovf <= 1'b1;
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                            r_state <= IDLE;
                        end else if (bus.data_eop) begin
                            r_frame_err <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            // strict compare keeps the lowest bin on ties
                            if (w_in_range && w_greater) begin
                                r_pk_mag_work <= bus.data_modulus;
                                r_pk_bin_work <= r_cnt;
                            end
                            r_cnt <= r_cnt + BIN_W'(1);
                        end
                    end

                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.peak_mag     = r_peak_mag;
    assign bus.peak_bin     = r_peak_bin;
    assign bus.dc_mag       = r_dc_mag;
    assign bus.result_valid = r_result_valid;
    assign bus.frame_err    = r_frame_err;
    assign bus.result_ovf   = r_result_ovf;

endmodule
